// File: rtl/tt_um_theandrewwang_count_checker.sv
// Purpose : checks that an upstream 8-bit counter increments by one (mod 256)
//           per valid sample, locks after three good increments and counts
//           increment errors seen while locked.
// Latency : all outputs are registered; they reflect a sample 1 cycle after
//           its sampling edge.
// Backpressure: none; every valid sample (ena & uio_in[0]) is consumed.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   ena      : design selected; valid is ignored while low
//   ui_in    : sampled counter value
//   uio_in   : [0] valid, [1] display select, [2] clear errors, [7:3] unused
//   uo_out   : err_cnt (select=0) or last accepted sample (select=1)
//   uio_out  : [4] locked, [5] err_pulse, [6] err_sticky, [7] err_sat
//   uio_oe   : constant 8'hF0
//
// Build option: define COUNT_CHECKER_STALL_EN to accept a repeated sample
// (equal to base) in SYNC/LOCKED as a harmless stall instead of a mismatch.

module tt_um_theandrewwang_count_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [1:0] run_q, run_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_pulse_q, err_pulse_d;
    logic       err_sticky_q, err_sticky_d;
    logic       disp_sel_q;

    logic       sample_vld;
    logic       clr_err;
    logic [7:0] base_inc;
    logic       is_inc;
    logic       stall_hit;
    logic       mismatch;
    logic       unused_bits;

    assign sample_vld = ena & uio_in[0];
    assign clr_err    = uio_in[2];
    assign base_inc   = base_q + 8'd1;
    assign is_inc     = (ui_in == base_inc);

`ifdef COUNT_CHECKER_STALL_EN
    assign stall_hit  = (ui_in == base_q);
`else
    assign stall_hit  = 1'b0;
`endif

    assign unused_bits = &{1'b0, uio_in[7:3]};

    // Next-state logic for the lock FSM and base/run tracking.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        run_d    = run_q;
        mismatch = 1'b0;
        if (sample_vld) begin
            unique case (state_q)
                ST_EMPTY: begin
                    base_d  = ui_in;
                    run_d   = 2'd0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (stall_hit) begin
                        // repeat accepted as a stall: nothing changes
                    end else if (is_inc) begin
                        base_d = ui_in;
                        run_d  = run_q + 2'd1;
                        // run_q==2 means this is the third good increment
                        if (run_q == 2'd2) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        base_d = ui_in;
                        run_d  = 2'd0;
                    end
                end
                ST_LOCKED: begin
                    if (stall_hit) begin
                        // repeat accepted as a stall: nothing changes
                    end else if (is_inc) begin
                        base_d = ui_in;
                    end else begin
                        mismatch = 1'b1;
                        base_d   = ui_in;
                        run_d    = 2'd0;
                        state_d  = ST_SYNC;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    base_d  = 8'd0;
                    run_d   = 2'd0;
                end
            endcase
        end
    end

    // Error bookkeeping; clear has priority over a coincident mismatch,
    // but the pulse still reports the mismatch.
    always_comb begin
        err_pulse_d  = mismatch;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_cnt_d    = 8'd0;
            err_sticky_d = 1'b0;
        end else if (mismatch) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            base_q       <= 8'd0;
            run_q        <= 2'd0;
            err_cnt_q    <= 8'd0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            disp_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            run_q        <= run_d;
            err_cnt_q    <= err_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            disp_sel_q   <= uio_in[1];
        end
    end

    // base_q always holds the last accepted sample, so it doubles as the
    // display value; outputs are pure functions of registers.
    assign uo_out  = disp_sel_q ? base_q : err_cnt_q;
    assign uio_out = {(err_cnt_q == 8'hFF), err_sticky_q, err_pulse_q,
                      (state_q == ST_LOCKED), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_theandrewwang_count_checker.md
TT_UM_THEANDREWWANG_COUNT_CHECKER -- requirements
Module: tt_um_theandrewwang_count_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (reset).
REQ-002 ena  input  1  design selected; when low, valid is treated as 0.
REQ-003 ui_in  input  8  sampled counter value from the upstream counter.
REQ-004 uio_in  input  8  [0]=valid, [1]=display select, [2]=clear errors; [7:3] ignored.
REQ-005 uo_out  output  8  display: err_cnt when uio_in[1]=0, else last accepted sample.
REQ-006 uio_out  output  8  [4]=locked, [5]=err_pulse, [6]=err_sticky, [7]=err_sat; [3:0]=0.
REQ-007 uio_oe  output  8  constant 8'hF0.

Function
REQ-008 A sample SHALL be taken on a rising clk edge when ena=1 and uio_in[0]=1; all outputs are registered and update 1 cycle after the sampling edge.
REQ-009 FSM states SHALL be EMPTY (no base), SYNC (base held, counting run), LOCKED.
REQ-010 EMPTY: any sample -> base=sample, run=0, go SYNC.
REQ-011 SYNC: sample==base+1 (mod 256) -> base=sample, run+1; the 3rd consecutive correct increment -> LOCKED; mismatch -> base=sample, run=0, stay SYNC, no error counted.
REQ-012 LOCKED: sample==base+1 (mod 256) -> base=sample, stay LOCKED; otherwise a mismatch.
REQ-013 LOCKED mismatch -> err_pulse=1 for exactly 1 cycle, err_sticky=1, err_cnt+1, base=sample, run=0, go SYNC.
REQ-014 Increment arithmetic SHALL be 8-bit modulo: 8'hFF followed by 8'h00 is a correct increment.
REQ-015 err_cnt SHALL be 8-bit saturating at 255; err_sat=1 while err_cnt==255.
REQ-016 Clear (uio_in[2]=1, sampled every edge regardless of ena) SHALL zero err_cnt, err_sticky and err_sat; it does not alter FSM state, base, run or locked.
REQ-017 Clear coincident with a LOCKED mismatch: clear wins for err_cnt/err_sticky/err_sat (all 0); err_pulse still asserts and the FSM still goes SYNC.
REQ-018 No valid sample -> FSM, base and run hold; err_pulse=0.
REQ-019 locked=1 exactly while the FSM is in LOCKED.
REQ-020 The display mux on uo_out SHALL use the registered uio_in[1] (1-cycle latency).

Reset
REQ-021 rst_n=0 SHALL asynchronously force: FSM=EMPTY, base=0, run=0, err_cnt=0, uo_out=0, uio_out=0; uio_oe stays 8'hF0.
REQ-022 Reset mid-stream SHALL discard lock; the first sample after release re-enters SYNC via EMPTY.

Configuration
REQ-023 Macro COUNT_CHECKER_STALL_EN: when defined, a sample equal to base (repeat) SHALL be accepted in SYNC and LOCKED with no state, run or error change; when undefined, a repeat is a mismatch per REQ-011/REQ-013.

Verification
REQ-024 Reset release, valid samples 10,11,12,13 -> locked=1 one cycle after the sample 13 edge, err_cnt=0.
REQ-025 Locked at base 20, sample 25 -> next cycle err_pulse=1 (one cycle), err_sticky=1, uo_out=1, locked=0; then 26,27,28 -> relock.
REQ-026 Locked stream 254,255,0,1 -> no error, locked stays 1.
REQ-027 Force 256 mismatches (alternate each mismatch with 3-sample relock) -> err_cnt=255, err_sat=1; clear pulse -> err_cnt=0, err_sat=0, err_sticky=0, locked unchanged.
REQ-028 Locked, sample 40 twice: with COUNT_CHECKER_STALL_EN -> no error; without -> err_cnt=1.
REQ-029 Locked at base 50, rst_n low 1 cycle, then sample 51 -> locked=0 (SYNC, run=0), err_cnt=0; ena=0 with valid=1 -> no state change.
